// File: rtl/prog_rate_divider.sv
// rtl/prog_rate_divider.sv - programmable rate divider with periodic and one-shot modes
module prog_rate_divider #(
   parameter int WIDTH          = 32,
   parameter int DEFAULT_PERIOD = 500000,
   parameter int DEFAULT_MODE   = 0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 load,
   input  logic [WIDTH-1:0]     period_in,
   input  logic                 mode_in,
   input  logic                 start,
   output logic                 out_pulse,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     count,
   output logic [CNT_WIDTH-1:0] pulse_count
);

   // busy and done are the state bits themselves, so both stay pure register outputs
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
   localparam logic [WIDTH-1:0] DEF_PERIOD  = WIDTH'(DEFAULT_PERIOD);
   localparam logic             DEF_MODE    = 1'(DEFAULT_MODE);
   localparam logic             MODE_ONESHOT = 1'b1;

   state_t               state;
   logic [WIDTH-1:0]     period_q;
   logic                 mode_q;
   logic [WIDTH-1:0]     counter;
   logic [WIDTH-1:0]     load_period;

   assign load_period = (period_in == '0) ? ONE : period_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         period_q    <= DEF_PERIOD;
         mode_q      <= DEF_MODE;
         counter     <= DEF_PERIOD - ONE;
         state       <= (DEF_MODE == MODE_ONESHOT) ? IDLE : RUN;
         out_pulse   <= 1'b0;
         pulse_count <= '0;
      end else if (load) begin
         period_q    <= load_period;
         mode_q      <= mode_in;
         counter     <= load_period - ONE;
         state       <= (mode_in == MODE_ONESHOT) ? IDLE : RUN;
         out_pulse   <= 1'b0;
         pulse_count <= '0;
      end else begin
         out_pulse <= 1'b0;
         if (start && mode_q == MODE_ONESHOT) begin
            // start from any state (re)arms the one-shot with a full period
            state   <= RUN;
            counter <= period_q - ONE;
         end else if (state == RUN && enable) begin
            if (counter == '0) begin
               counter     <= period_q - ONE;
               out_pulse   <= 1'b1;
               pulse_count <= pulse_count + CNT_WIDTH'(1);
               if (mode_q == MODE_ONESHOT)
                  state <= DONE;
            end else begin
               counter <= counter - ONE;
            end
         end
      end
   end

   assign busy  = state[0];
   assign done  = state[1];
   assign count = counter;

endmodule

// File: tb/tb_prog_rate_divider.sv
// tb/tb_prog_rate_divider.sv - directed self-checking bench for prog_rate_divider
module tb_prog_rate_divider;

   localparam int WIDTH = 32;
   localparam int CNTW  = 2;

   logic              clock = 1'b0;
   logic              reset, enable, load, mode_in, start;
   logic [WIDTH-1:0]  period_in;
   logic              out_pulse, busy, done;
   logic [WIDTH-1:0]  count;
   logic [CNTW-1:0]   pulse_count;

   int n_checks = 0;
   int n_fail   = 0;

   prog_rate_divider #(
      .WIDTH(WIDTH), .DEFAULT_PERIOD(10), .DEFAULT_MODE(0), .CNT_WIDTH(CNTW)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .period_in(period_in), .mode_in(mode_in), .start(start),
      .out_pulse(out_pulse), .busy(busy), .done(done),
      .count(count), .pulse_count(pulse_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   int first_p, second_p, npulse;

   initial begin
      reset = 1'b1; enable = 1'b0; load = 1'b0; mode_in = 1'b0;
      start = 1'b0; period_in = '0;
      step();
      reset = 1'b0;

      check("rst_count", count, 9);
      check("rst_pulse", out_pulse, 0);
      check("rst_pcount", pulse_count, 0);
      check("rst_busy", busy, 1);
      check("rst_done", done, 0);

      // default period 10: pulses after edge 10 and 20
      enable = 1'b1;
      first_p = -1; second_p = -1; npulse = 0;
      for (int k = 1; k <= 25; k++) begin
         step();
         if (out_pulse) begin
            npulse++;
            if (first_p < 0) first_p = k;
            else if (second_p < 0) second_p = k;
         end
      end
      check("def_first", first_p, 10);
      check("def_second", second_p, 20);
      check("def_npulse", npulse, 2);
      check("def_pcount", pulse_count, 2);
      check("def_busy", busy, 1);
      check("def_done", done, 0);

      // periodic P=5
      load = 1'b1; period_in = 5; mode_in = 1'b0;
      step();
      load = 1'b0;
      check("p5_load_count", count, 4);
      check("p5_load_pcount", pulse_count, 0);
      check("p5_load_pulse", out_pulse, 0);
      check("p5_load_busy", busy, 1);
      for (int k = 1; k <= 10; k++) begin
         step();
         check("p5_count", count, (4 - (k % 5) + 5) % 5);
         check("p5_pulse", out_pulse, (k % 5) == 0);
      end

      // pause at count 2
      step(); step();
      check("pause_pre", count, 2);
      enable = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         check("pause_count", count, 2);
         check("pause_pulse", out_pulse, 0);
      end
      check("pause_pcount", pulse_count, 2);
      enable = 1'b1;
      step(); check("resume1", out_pulse, 0);
      step(); check("resume2", out_pulse, 0);
      step(); check("resume3", out_pulse, 1);
      check("resume_pcount", pulse_count, 3);

      // period 0 behaves as 1; 2-bit tally wraps after 4 pulses
      load = 1'b1; period_in = 0; mode_in = 1'b0;
      step();
      load = 1'b0;
      check("p1_count", count, 0);
      check("p1_pcount0", pulse_count, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("p1_pulse", out_pulse, 1);
         check("p1_count_k", count, 0);
      end
      check("p1_wrap", pulse_count, 1);

      // one-shot, period 4
      load = 1'b1; period_in = 4; mode_in = 1'b1;
      step();
      load = 1'b0;
      check("os_idle_busy", busy, 0);
      check("os_idle_done", done, 0);
      check("os_idle_count", count, 3);
      npulse = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (out_pulse) npulse++;
      end
      check("os_idle_npulse", npulse, 0);
      check("os_idle_count2", count, 3);

      start = 1'b1; step(); start = 1'b0;
      check("os_run_busy", busy, 1);
      check("os_run_count", count, 3);
      for (int k = 0; k < 3; k++) begin
         step();
         check("os_run_nopulse", out_pulse, 0);
      end
      step();
      check("os_pulse", out_pulse, 1);
      check("os_done", done, 1);
      check("os_busy", busy, 0);
      check("os_done_count", count, 3);
      check("os_pcount1", pulse_count, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("os_after_pulse", out_pulse, 0);
         check("os_after_done", done, 1);
      end

      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("os2_pulse", out_pulse, 1);
      check("os2_pcount", pulse_count, 2);

      // re-arm at count 1
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      check("rearm_pre", count, 1);
      start = 1'b1; step(); start = 1'b0;
      check("rearm_count", count, 3);
      check("rearm_pulse", out_pulse, 0);
      check("rearm_busy", busy, 1);
      step(); step(); step();
      check("rearm_zero", count, 0);
      step();
      check("rearm_fire", out_pulse, 1);
      check("rearm_pcount", pulse_count, 3);
      check("rearm_done", done, 1);

      // reset mid-run of a one-shot
      start = 1'b1; step(); start = 1'b0;
      step();
      check("mid_busy", busy, 1);
      reset = 1'b1; step(); reset = 1'b0;
      check("mrst_count", count, 9);
      check("mrst_busy", busy, 1);
      check("mrst_done", done, 0);
      check("mrst_pcount", pulse_count, 0);
      check("mrst_pulse", out_pulse, 0);

      // load and start together: start ignored
      load = 1'b1; start = 1'b1; period_in = 6; mode_in = 1'b1;
      step();
      load = 1'b0; start = 1'b0;
      check("ls_busy", busy, 0);
      check("ls_done", done, 0);
      check("ls_count", count, 5);
      step(); step(); step();
      check("ls_busy2", busy, 0);
      check("ls_count2", count, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_rate_divider.md
Name: prog_rate_divider

Overview:
Parametrised, run-time programmable rate divider. It is the successor to the fixed-period centisecond divider. It adds a loadable period, a free-running periodic mode and a triggered one-shot mode, an enable/pause control, a readable down-counter and a wrapping pulse tally. It sits between the 50 MHz board clock and the timekeeping/display logic. With default parameters it produces a one-cycle pulse every 500,000 clocks (0.01 s).

Parameters:
WIDTH, 32, bit width of period register and down-counter
DEFAULT_PERIOD, 500000, period loaded at reset (clock cycles per pulse); must be >= 1 and < 2^WIDTH
DEFAULT_MODE, 0, mode at reset: 0 = periodic, 1 = one-shot
CNT_WIDTH, 16, width of pulse tally

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; returns all state to reset values
enable  input  1  count enable; low = pause (counter frozen, no pulses)
load  input  1  one-cycle strobe: latch period_in and mode_in, restart
period_in  input  WIDTH  new period in cycles; 0 is treated as 1
mode_in  input  1  new mode, latched on load
start  input  1  one-cycle trigger for one-shot mode; ignored in periodic mode
out_pulse  output  1  registered, high for exactly one cycle per terminal count
busy  output  1  high while state = RUN
done  output  1  one-shot complete; high in DONE state
count  output  WIDTH  current down-counter value
pulse_count  output  CNT_WIDTH  number of pulses emitted since reset/load; wraps modulo 2^CNT_WIDTH

Behaviour:
- Registers:
  - period_q: reset DEFAULT_PERIOD.
  - mode_q: reset DEFAULT_MODE.
  - counter: reset period_q-1.
  - state.
  - out_pulse: reset 0.
  - pulse_count: reset 0.
- State machine has three states: IDLE, RUN, DONE.
  - On reset or load, state goes to RUN if the latched mode is periodic, else IDLE.
- Counting happens only in RUN with enable=1.
  - If counter != 0: counter decrements.
  - If counter == 0: counter reloads period_q-1 and out_pulse is set to 1 on that edge, so it is high for the following cycle only.
  - In every other cycle out_pulse is 0.
- Latency: with period P and enable held high from reset release, out_pulse is first high during the cycle after the P-th clock edge. After that it is high once every P cycles.
- P = 1: counter stays at 0; in periodic mode out_pulse is high every enabled cycle.
- Periodic mode: remains in RUN indefinitely; start has no effect.
- One-shot mode:
  - IDLE --start--> RUN, with counter reloaded to period_q-1.
  - RUN --terminal count--> DONE, with a single out_pulse.
  - DONE --start--> RUN, with counter reloaded.
  - start while in RUN re-arms: counter reloads period_q-1, no pulse, state stays RUN.
  - In IDLE and DONE the counter holds period_q-1.
- enable=0: counter, state and pulse_count hold; out_pulse is 0. start and load are still honoured while enable=0. The counter only resumes once enable returns.
- load:
  - period_q <= (period_in==0 ? 1 : period_in)
  - mode_q <= mode_in
  - counter <= new period-1
  - pulse_count <= 0
  - out_pulse <= 0
  - state is set per the reset rule.
- Priority, highest first: reset > load > start > count. With load and start in the same cycle, start is ignored.
- pulse_count increments by 1 on each edge that sets out_pulse. It wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- done = (state==DONE). busy = (state==RUN).
- Outputs are direct register outputs, with no combinational path from inputs.

Test Plan:
- Reset with defaults, enable=1 for 1,100,000 cycles → out_pulse high at cycles 500,000 and 1,000,000 only; pulse_count=2; busy=1, done=0.
- load period_in=5, mode_in=0, then enable=1 → out_pulse every 5th cycle, count sequence 4,3,2,1,0,4…; pulse_count=0 directly after load.
- Periodic with P=5: drop enable for 7 cycles mid-count at count=2 → count holds 2, no pulse; after re-enable the pulse arrives 3 cycles later.
- load period_in=0 → behaves as P=1; out_pulse high every enabled cycle; count constant 0.
- One-shot with period 4:
  - After load, IDLE with no pulses for 20 cycles.
  - start → single pulse 4 cycles later, then done=1, busy=0.
  - start again → one more pulse.
  - start issued at count=1 → counter re-arms to 3, no pulse.
- Corner cases:
  - load and start in the same cycle → load applied, state IDLE, no run.
  - reset asserted mid-RUN → next cycle all outputs at reset values.
  - With CNT_WIDTH=2 and P=1: after 5 pulses, pulse_count=1 (wrap).
